// File: rtl/mux_nto1_scan.sv
// N-channel registered mux with manual select or dwell-timed round-robin
// scan, and a valid/ready output slot.
//
// Ports:
//   clk, rst_n      rising-edge clock, async active-low reset
//   in_data         packed channels, ch k at [k*WIDTH +: WIDTH]
//   sel             manual channel select
//   mode            0 = manual, 1 = auto-scan
//   en              capture enable
//   out_ready       downstream accepts the held sample
//   out_data/out_ch registered sample and its channel index
//   out_valid       output slot occupied
//   out_err         sample came from an out-of-range select
//   out_par         even parity of out_data (only with MUX_PARITY_EN)
//
// Build option: define MUX_PARITY_EN to add the out_par port.
module mux_nto1_scan #(
  parameter int WIDTH = 8,
  parameter int N_CH  = 8,
  parameter int SEL_W = 3,
  parameter int DWELL = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_CH*WIDTH-1:0]   in_data,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    mode,
  input  logic                    en,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_ch,
  output logic                    out_valid,
  output logic                    out_err
`ifdef MUX_PARITY_EN
  ,
  output logic                    out_par
`endif
);

  if (SEL_W != $clog2(N_CH)) begin : g_selw_chk
    $error("SEL_W must equal $clog2(N_CH)");
  end

  localparam int NSLOT = 1 << SEL_W;
  localparam int DW_W  = (DWELL > 1) ? $clog2(DWELL) : 1;

  localparam logic [SEL_W:0]   NCH_L   = N_CH[SEL_W:0];
  localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(N_CH - 1);
  localparam logic [DW_W-1:0]  DW_LAST = DW_W'(DWELL - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MAN,
    S_SCAN
  } state_t;

  state_t state_q, state_d;

  logic [SEL_W-1:0] ch_q, ch_d;
  logic [DW_W-1:0]  dw_q, dw_d;

  logic [WIDTH-1:0] data_q;
  logic [SEL_W-1:0] och_q;
  logic             valid_q;
  logic             err_q;

  logic             slot_free;
  logic             cap;
  logic [SEL_W-1:0] cap_ch;
  logic             cap_in;

  // Padded to the full select range; unused slots read as zero so an
  // out-of-range manual select naturally captures 0.
  logic [WIDTH-1:0] ch_w [NSLOT];

  for (genvar k = 0; k < NSLOT; k++) begin : g_ch
    if (k < N_CH) begin : g_real
      assign ch_w[k] = in_data[k*WIDTH +: WIDTH];
    end else begin : g_pad
      assign ch_w[k] = '0;
    end
  end

  assign slot_free = !valid_q || out_ready;
  assign cap_in    = ({1'b0, cap_ch} < NCH_L);

  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    dw_d    = dw_q;
    cap     = 1'b0;
    cap_ch  = sel;
    if (!en) begin
      state_d = S_IDLE;
    end else if (!mode) begin
      // Manual capture follows the inputs directly, so a mode
      // switch takes effect on the very next capture edge.
      state_d = S_MAN;
      cap     = slot_free;
    end else if (state_q != S_SCAN) begin
      state_d = S_SCAN;
      ch_d    = '0;
      dw_d    = '0;
    end else if (dw_q != DW_LAST) begin
      dw_d = dw_q + DW_W'(1);
    end else if (slot_free) begin
      cap    = 1'b1;
      cap_ch = ch_q;
      dw_d   = '0;
      ch_d   = (ch_q == LAST_CH) ? '0 : ch_q + SEL_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ch_q    <= '0;
      dw_q    <= '0;
      data_q  <= '0;
      och_q   <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      dw_q    <= dw_d;
      if (cap) begin
        data_q  <= ch_w[cap_ch];
        och_q   <= cap_ch;
        valid_q <= 1'b1;
        err_q   <= !cap_in;
      end else if (out_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign out_data  = data_q;
  assign out_ch    = och_q;
  assign out_valid = valid_q;
  assign out_err   = err_q;

`ifdef MUX_PARITY_EN
  logic par_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_q <= 1'b0;
    end else if (cap) begin
      par_q <= ^ch_w[cap_ch];
    end
  end

  assign out_par = par_q;
`endif

endmodule

// File: tb/tb_mux_nto1_scan.sv
// Scoreboard bench for mux_nto1_scan: an 8-channel/dwell-4 instance and a
// 6-channel/dwell-1 instance share stimulus; each has its own queue.
module tb_mux_nto1_scan;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] din;
  logic [2:0]  sel;
  logic        mode, en, rdy;

  logic [7:0]  d0, d6;
  logic [2:0]  c0, c6;
  logic        v0, v6, e0, e6;
`ifdef MUX_PARITY_EN
  logic        p0, p6;
`endif

  always #5 clk = ~clk;

  mux_nto1_scan #(
    .WIDTH(8), .N_CH(8), .SEL_W(3), .DWELL(4)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .in_data(din), .sel(sel),
    .mode(mode), .en(en), .out_ready(rdy),
    .out_data(d0), .out_ch(c0), .out_valid(v0), .out_err(e0)
`ifdef MUX_PARITY_EN
    , .out_par(p0)
`endif
  );

  mux_nto1_scan #(
    .WIDTH(8), .N_CH(6), .SEL_W(3), .DWELL(1)
  ) u_dut6 (
    .clk(clk), .rst_n(rst_n), .in_data(din[47:0]), .sel(sel),
    .mode(mode), .en(en), .out_ready(rdy),
    .out_data(d6), .out_ch(c6), .out_valid(v6), .out_err(e6)
`ifdef MUX_PARITY_EN
    , .out_par(p6)
`endif
  );

  typedef struct packed {
    logic [7:0] d;
    logic [2:0] c;
    logic       e;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  bit   scn[2];
  int   tk[2];
  int   mc[2];
  int   vectors = 0;
  int   miscompares = 0;
  bit   done = 1'b0;

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: one sample slot per instance, represented by its
  // queue; a capture may only happen when that slot is empty at the edge.
  task automatic step(int k);
    int   n, dw, c, sz;
    bit   cap;
    exp_t x;
    n   = (k == 0) ? 8 : 6;
    dw  = (k == 0) ? 4 : 1;
    sz  = (k == 0) ? q0.size() : q1.size();
    cap = 1'b0;
    c   = 0;
    if (!en) begin
      scn[k] = 1'b0;
    end else if (!mode) begin
      scn[k] = 1'b0;
      if (sz == 0) begin
        cap = 1'b1;
        c   = int'(sel);
      end
    end else if (!scn[k]) begin
      scn[k] = 1'b1;
      tk[k]  = 0;
      mc[k]  = 0;
    end else if (tk[k] == dw - 1) begin
      if (sz == 0) begin
        cap   = 1'b1;
        c     = mc[k];
        mc[k] = (mc[k] + 1) % n;
        tk[k] = 0;
      end
    end else begin
      tk[k]++;
    end
    if (cap) begin
      x.c = 3'(c);
      x.e = (c >= n);
      x.d = x.e ? 8'h00 : din[c*8 +: 8];
      if (k == 0) q0.push_back(x);
      else q1.push_back(x);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) begin
      step(0);
      step(1);
    end
    #1;
  endtask

  task automatic mon(int k);
    logic [7:0] d;
    logic [2:0] c;
    logic       v, e;
    int         sz;
    exp_t       x;
    string      s;
`ifdef MUX_PARITY_EN
    logic       p;
    p = (k == 0) ? p0 : p6;
`endif
    d  = (k == 0) ? d0 : d6;
    c  = (k == 0) ? c0 : c6;
    v  = (k == 0) ? v0 : v6;
    e  = (k == 0) ? e0 : e6;
    s  = (k == 0) ? "n8" : "n6";
    sz = (k == 0) ? q0.size() : q1.size();
    check({s, ".valid"}, 32'(v), 32'(sz > 0));
    if (sz > 0) begin
      x = (k == 0) ? q0[0] : q1[0];
      if (v) begin
        check({s, ".data"}, 32'(d), 32'(x.d));
        check({s, ".ch"}, 32'(c), 32'(x.c));
        check({s, ".err"}, 32'(e), 32'(x.e));
`ifdef MUX_PARITY_EN
        check({s, ".par"}, 32'(p), 32'(^x.d));
`endif
      end
      if (rdy) begin
        if (k == 0) void'(q0.pop_front());
        else void'(q1.pop_front());
      end
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && !done) begin
        mon(0);
        mon(1);
      end
    end
  end

  task automatic chk_zero(string tag);
    check({tag, ".v0"}, 32'(v0), 32'd0);
    check({tag, ".d0"}, 32'(d0), 32'd0);
    check({tag, ".c0"}, 32'(c0), 32'd0);
    check({tag, ".e0"}, 32'(e0), 32'd0);
    check({tag, ".v6"}, 32'(v6), 32'd0);
    check({tag, ".d6"}, 32'(d6), 32'd0);
    check({tag, ".c6"}, 32'(c6), 32'd0);
    check({tag, ".e6"}, 32'(e6), 32'd0);
`ifdef MUX_PARITY_EN
    check({tag, ".p0"}, 32'(p0), 32'd0);
    check({tag, ".p6"}, 32'(p6), 32'd0);
`endif
  endtask

  task automatic model_reset();
    q0.delete();
    q1.delete();
    for (int k = 0; k < 2; k++) begin
      scn[k] = 1'b0;
      tk[k]  = 0;
      mc[k]  = 0;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    logic [7:0] ch2;
    rst_n = 1'b0;
    en    = 1'b0;
    mode  = 1'b0;
    sel   = '0;
    rdy   = 1'b1;
    din   = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    rst_n = 1'b1;
    tick();
    tick();

    // manual select, one-cycle latency
    din[5*8 +: 8] = 8'hA5;
    sel  = 3'd5;
    en   = 1'b1;
    tick();
    check("man.data", 32'(d0), 32'hA5);
    check("man.ch", 32'(c0), 32'd5);
    check("man.valid", 32'(v0), 32'd1);

    // out-of-range select on the 6-channel instance
    ch2 = 8'h3C;
    din[2*8 +: 8] = ch2;
    sel = 3'd7;
    tick();
    check("oor.data", 32'(d6), 32'd0);
    check("oor.err", 32'(e6), 32'd1);
    check("oor.ch", 32'(c6), 32'd7);
    sel = 3'd2;
    tick();
    check("oor.clr", 32'(e6), 32'd0);
    check("oor.data2", 32'(d6), 32'(ch2));

`ifdef MUX_PARITY_EN
    sel = 3'd1;
    din[8 +: 8] = 8'h07;
    tick();
    check("par.07", 32'(p0), 32'd1);
    din[8 +: 8] = 8'h03;
    tick();
    check("par.03", 32'(p0), 32'd0);
`endif

    // scan: first sample 4 cycles after entry, then every 4, wrapping
    din  = 64'h8877_6655_4433_2211;
    mode = 1'b1;
    tick();
    for (int i = 0; i <= 8; i++) begin
      n = 0;
      while (1) begin
        tick();
        n++;
        if (v0 || n >= 20) break;
      end
      check("scan.gap", 32'(n), 32'd4);
      check("scan.ch", 32'(c0), 32'(i % 8));
    end

    // backpressure at channel 3
    n = 0;
    while (!(v0 && c0 == 3'd3) && n < 100) begin
      tick();
      n++;
    end
    check("bp.reach", 32'(v0 && c0 == 3'd3), 32'd1);
    rdy = 1'b0;
    repeat (10) tick();
    check("bp.hold.ch", 32'(c0), 32'd3);
    check("bp.hold.v", 32'(v0), 32'd1);
    check("bp.hold.d", 32'(d0), 32'h44);
    rdy = 1'b1;
    tick();
    check("bp.next.ch", 32'(c0), 32'd4);
    check("bp.next.v", 32'(v0), 32'd1);

    // randomized traffic with a mid-stream async reset
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) begin
        rst_n = 1'b0;
        #1;
        chk_zero("midrst");
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
      end
      din  = {$urandom, $urandom};
      sel  = 3'($urandom_range(0, 7));
      rdy  = ($urandom_range(0, 3) != 0);
      en   = ($urandom_range(0, 19) != 0);
      if ($urandom_range(0, 29) == 0) mode = ~mode;
      tick();
    end

    // drain
    en  = 1'b0;
    rdy = 1'b1;
    repeat (5) tick();
    check("drain.q0", 32'(q0.size()), 32'd0);
    check("drain.q1", 32'(q1.size()), 32'd0);
    check("drain.v0", 32'(v0), 32'd0);
    check("drain.v6", 32'(v6), 32'd0);
    done = 1'b1;
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
